// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: load-use hazard detection, stall hold and flush bubble insertion.
// Optional macro PIPE_PERF_CNT_EN adds saturating bubble/stall counters.
module id_ex_reg #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [1:0]    id_aluOp,
  input  logic [5:0]    id_funct,
  input  logic          id_aluSrc,
  input  logic          id_regDst,
  input  logic          id_memRead,
  input  logic          id_memWrite,
  input  logic          id_memToReg,
  input  logic          id_regWrite,
  input  logic [DW-1:0] id_rsData,
  input  logic [DW-1:0] id_rtData,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          ex_stall,
  input  logic          ex_flush,
  output logic          hazard_stall,
  output logic          ex_valid,
  output logic [1:0]    ex_aluOp,
  output logic [5:0]    ex_funct,
  output logic          ex_aluSrc,
  output logic          ex_regDst,
  output logic          ex_memRead,
  output logic          ex_memWrite,
  output logic          ex_memToReg,
  output logic          ex_regWrite,
  output logic [DW-1:0] ex_rsData,
  output logic [DW-1:0] ex_rtData,
  output logic [DW-1:0] ex_imm,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic [RW-1:0] ex_writeReg
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [15:0]   bubble_cnt,
  output logic [15:0]   stall_cnt
`endif
);

  logic load_bubble;
  logic hold;

  // Stores matching on rt also stall: conservative, keeps the compare simple.
  assign hazard_stall = ex_valid & ex_memRead & (ex_rt != '0) & id_valid &
                        ((ex_rt == id_rs) | (ex_rt == id_rt));

  // Flush beats stall; stall beats a load-use bubble.
  assign load_bubble = ex_flush | (~ex_stall & hazard_stall);
  assign hold        = ~ex_flush & ex_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || load_bubble) begin
      ex_valid    <= 1'b0;
      ex_aluOp    <= '0;
      ex_funct    <= '0;
      ex_aluSrc   <= 1'b0;
      ex_regDst   <= 1'b0;
      ex_memRead  <= 1'b0;
      ex_memWrite <= 1'b0;
      ex_memToReg <= 1'b0;
      ex_regWrite <= 1'b0;
      ex_rsData   <= '0;
      ex_rtData   <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_writeReg <= '0;
    end else if (!hold) begin
      // An invalid slot carries no control so it can never write or touch memory.
      ex_valid    <= id_valid;
      ex_aluOp    <= id_valid ? id_aluOp : 2'b00;
      ex_funct    <= id_valid ? id_funct : 6'd0;
      ex_aluSrc   <= id_valid & id_aluSrc;
      ex_regDst   <= id_valid & id_regDst;
      ex_memRead  <= id_valid & id_memRead;
      ex_memWrite <= id_valid & id_memWrite;
      ex_memToReg <= id_valid & id_memToReg;
      ex_regWrite <= id_valid & id_regWrite;
      ex_rsData   <= id_rsData;
      ex_rtData   <= id_rtData;
      ex_imm      <= id_imm;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd       <= id_rd;
      ex_writeReg <= id_regDst ? id_rd : id_rt;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (load_bubble && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
      if (hold && stall_cnt != 16'hFFFF)         stall_cnt  <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: capture, load-use, zero register, flush/stall priority, async reset.
module tb_id_ex_reg;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [1:0]  id_aluOp;
  logic [5:0]  id_funct;
  logic        id_aluSrc, id_regDst, id_memRead, id_memWrite, id_memToReg, id_regWrite;
  logic [31:0] id_rsData, id_rtData, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_stall, ex_flush;
  logic        hazard_stall, ex_valid;
  logic [1:0]  ex_aluOp;
  logic [5:0]  ex_funct;
  logic        ex_aluSrc, ex_regDst, ex_memRead, ex_memWrite, ex_memToReg, ex_regWrite;
  logic [31:0] ex_rsData, ex_rtData, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_writeReg;
`ifdef PIPE_PERF_CNT_EN
  logic [15:0] bubble_cnt, stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_aluOp(id_aluOp), .id_funct(id_funct),
    .id_aluSrc(id_aluSrc), .id_regDst(id_regDst), .id_memRead(id_memRead),
    .id_memWrite(id_memWrite), .id_memToReg(id_memToReg), .id_regWrite(id_regWrite),
    .id_rsData(id_rsData), .id_rtData(id_rtData), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_aluOp(ex_aluOp), .ex_funct(ex_funct),
    .ex_aluSrc(ex_aluSrc), .ex_regDst(ex_regDst), .ex_memRead(ex_memRead),
    .ex_memWrite(ex_memWrite), .ex_memToReg(ex_memToReg), .ex_regWrite(ex_regWrite),
    .ex_rsData(ex_rsData), .ex_rtData(ex_rtData), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_writeReg(ex_writeReg)
`ifdef PIPE_PERF_CNT_EN
    , .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one decoded instruction: v, aluOp, funct, aluSrc, regDst, memRead, memWrite, memToReg, regWrite
  task automatic set_id(input logic v, input logic [1:0] op, input logic [5:0] fn,
                        input logic asrc, input logic rdst, input logic mrd, input logic mwr,
                        input logic m2r, input logic rwr, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm);
    id_valid = v; id_aluOp = op; id_funct = fn; id_aluSrc = asrc; id_regDst = rdst;
    id_memRead = mrd; id_memWrite = mwr; id_memToReg = m2r; id_regWrite = rwr;
    id_rs = rs; id_rt = rt; id_rd = rd; id_rsData = rsd; id_rtData = rtd; id_imm = imm;
  endtask

  initial begin
    rst_n = 1'b0; ex_stall = 1'b0; ex_flush = 1'b0;
    set_id(0, 2'b00, 6'd0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    #2;
    chk("reset_valid", ex_valid, 0);
    chk("reset_hazard", hazard_stall, 0);
    rst_n = 1'b1;
    tick();

    // add r4, r2, r3
    set_id(1, 2'b10, 6'h20, 0, 1, 0, 0, 0, 1, 5'd2, 5'd3, 5'd4, 32'd5, 32'd7, 32'd0);
    tick();
    chk("add_writeReg", ex_writeReg, 4);
    chk("add_aluOp", ex_aluOp, 2'b10);
    chk("add_funct", ex_funct, 6'h20);
    chk("add_rsData", ex_rsData, 5);
    chk("add_rtData", ex_rtData, 7);
    chk("add_valid_rw", {ex_valid, ex_regWrite}, 2'b11);

    // lw r8, 4(r1) then add r10, r8, r9 -> load-use
    set_id(1, 2'b00, 6'd0, 1, 0, 1, 0, 1, 1, 5'd1, 5'd8, 5'd0, 32'd100, 32'd0, 32'd4);
    tick();
    chk("lw_memRead", ex_memRead, 1);
    chk("lw_writeReg", ex_writeReg, 8);
    set_id(1, 2'b10, 6'h20, 0, 1, 0, 0, 0, 1, 5'd8, 5'd9, 5'd10, 32'd11, 32'd12, 32'd0);
    #1;
    chk("lu_hazard", hazard_stall, 1);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_rw", ex_regWrite, 0);
    chk("lu_hazard_clear", hazard_stall, 0);
    tick();
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_rs", ex_rs, 8);
    chk("lu_add_writeReg", ex_writeReg, 10);

    // lw r8 then sw r8: conservative stall, held by ex_stall for one edge
    set_id(1, 2'b00, 6'd0, 1, 0, 1, 0, 1, 1, 5'd1, 5'd8, 5'd0, 32'd100, 32'd0, 32'd4);
    tick();
    set_id(1, 2'b00, 6'd0, 1, 0, 0, 1, 0, 0, 5'd1, 5'd8, 5'd0, 32'd100, 32'd55, 32'd8);
    #1;
    chk("sw_hazard", hazard_stall, 1);
    ex_stall = 1'b1;
    tick();
    chk("stall_hz_memRead", ex_memRead, 1);
    chk("stall_hz_hazard", hazard_stall, 1);
    ex_stall = 1'b0;
    tick();
    chk("sw_bubble", {ex_valid, ex_memWrite}, 2'b00);
    tick();
    chk("sw_capture", {ex_valid, ex_memWrite, ex_imm[7:0]}, {2'b11, 8'd8});

    // lw r0 then add r6, r0, r5: no hazard on r0
    set_id(1, 2'b00, 6'd0, 1, 0, 1, 0, 1, 1, 5'd1, 5'd0, 5'd0, 32'd100, 32'd0, 32'd4);
    tick();
    set_id(1, 2'b10, 6'h20, 0, 1, 0, 0, 0, 1, 5'd0, 5'd5, 5'd6, 32'd0, 32'd9, 32'd0);
    #1;
    chk("zero_hazard", hazard_stall, 0);
    tick();
    chk("zero_capture", {ex_valid, ex_rs, ex_writeReg}, {1'b1, 5'd0, 5'd6});

    // Invalid slot loses its control bits
    set_id(0, 2'b10, 6'h20, 1, 1, 1, 1, 1, 1, 5'd3, 5'd4, 5'd5, 32'd1, 32'd2, 32'd3);
    tick();
    chk("inv_ctrl", {ex_valid, ex_regWrite, ex_memWrite, ex_memRead}, 4'b0000);

    // Flush and stall together with a valid sw: flush wins
    set_id(1, 2'b00, 6'd0, 1, 0, 0, 1, 0, 0, 5'd2, 5'd3, 5'd0, 32'd77, 32'd88, 32'd12);
    ex_flush = 1'b1; ex_stall = 1'b1;
    tick();
    chk("flush_stall", {ex_valid, ex_memWrite}, 2'b00);
    chk("flush_data", ex_rsData, 0);
    ex_flush = 1'b0; ex_stall = 1'b0;

    // Asynchronous reset mid-cycle with live contents
    set_id(1, 2'b10, 6'h22, 0, 1, 0, 0, 0, 1, 5'd7, 5'd8, 5'd9, 32'h1234, 32'h5678, 32'd0);
    tick();
    chk("pre_reset_rsData", ex_rsData, 32'h1234);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {ex_valid, ex_regWrite, ex_funct, ex_writeReg}, 0);
    chk("async_reset_data", ex_rsData, 0);
    rst_n = 1'b1;

    // Stall hold for 3 cycles while ID changes
    tick();
    chk("hold_start", ex_rsData, 32'h1234);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_rsData = 32'h100 + i; id_rd = 5'(20 + i); id_funct = 6'(i);
      tick();
      chk("hold_rsData", ex_rsData, 32'h1234);
      chk("hold_ctrl", {ex_writeReg, ex_funct}, {5'd9, 6'h22});
    end
`ifdef PIPE_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 3);
    chk("bubble_cnt_zero", bubble_cnt, 0);
`endif
    // Reset while stalled discards the held instruction
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_stall", {ex_valid, ex_rsData}, 0);
    rst_n = 1'b1;
    ex_stall = 1'b0;

`ifdef PIPE_PERF_CNT_EN
    ex_flush = 1'b1;
    repeat (65540) tick();
    chk("bubble_cnt_sat", bubble_cnt, 16'hFFFF);
    ex_flush = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
ID/EX pipeline register of the 5-stage MIPS core. It sits between the decode stage (main control, register file, sign-extend) and the EX stage. It feeds aluOp/funct to the ALU control decoder and operands to the ALU. It contains load-use hazard detection and supports stall and flush (bubble insertion) for branch redirect.

Parameters:
DW, 32, datapath width of register operands and sign-extended immediate
RW, 5, register-specifier width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_aluOp  in  2  ALU op class from main control
id_funct  in  6  instruction[5:0]
id_aluSrc  in  1  ALU B-operand selects immediate
id_regDst  in  1  write register is rd (1) or rt (0)
id_memRead  in  1  load
id_memWrite  in  1  store
id_memToReg  in  1  writeback from memory
id_regWrite  in  1  writes register file
id_rsData  in  DW  register-file read port 1
id_rtData  in  DW  register-file read port 2
id_imm  in  DW  sign-extended immediate
id_rs, id_rt, id_rd  in  RW each  register specifiers
ex_stall  in  1  downstream stall (hold contents)
ex_flush  in  1  branch/jump redirect: kill the instruction entering EX
hazard_stall  out  1  load-use stall request to PC and IF/ID (combinational)
ex_valid  out  1  EX holds a real instruction
ex_aluOp, ex_funct, ex_aluSrc, ex_regDst, ex_memRead, ex_memWrite, ex_memToReg, ex_regWrite  out  as inputs  registered copies
ex_rsData, ex_rtData, ex_imm  out  DW  registered operands
ex_rs, ex_rt, ex_rd  out  RW  registered specifiers
ex_writeReg  out  RW  registered destination: id_regDst ? id_rd : id_rt

Behaviour:
- Reset (rst_n=0, asynchronous): every ex_* output is 0, so the register holds a NOP bubble. hazard_stall is 0 because ex_memRead=0. Reset mid-stall discards the held instruction.
- Load-use detection (combinational): hazard_stall = ex_valid & ex_memRead & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt)). A store whose rt matches also stalls; this is a conservative choice.
- Per-edge update priority (highest first):
  1. ex_flush=1: load bubble. ex_valid, all control bits, aluOp and funct become 0. Data and specifier fields become 0.
  2. ex_stall=1: hold every register unchanged.
  3. hazard_stall=1: load bubble (same as flush). The ID instruction is re-presented next cycle by the held IF/ID.
  4. Otherwise: capture every id_* field.
- A capture with id_valid=0 also zeroes all control bits, so an invalid slot never has write or memory side effects.
- Flush and stall asserted together: flush wins.
- Stall together with hazard_stall: hold wins. hazard_stall stays high while the load sits in EX.
- Latency: exactly 1 cycle from ID input to EX output. No combinational path from id_* to ex_* except through hazard_stall.
- A bubble's aluOp=00 makes the downstream ALU control decode ADD. This is harmless because regWrite, memRead and memWrite are all 0.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- When defined: adds outputs bubble_cnt[15:0] and stall_cnt[15:0], reset to 0.
  - bubble_cnt increments on each edge where a bubble is loaded (flush or hazard).
  - stall_cnt increments on each edge where ex_stall holds the register.
  - Both counters saturate at 16'hFFFF (no wrap).
- When undefined: the ports and logic are absent, and the remaining behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with nonzero ex contents -> all ex_* = 0 immediately, hazard_stall=0.
- Normal capture: id_valid=1, add rs=2, rt=3, rd=4, regDst=1, regWrite=1, aluOp=10, funct=100000, rsData=5, rtData=7 -> next edge ex_writeReg=4, ex_aluOp=10, ex_funct=20h, ex_rsData=5, ex_rtData=7.
- Load-use: ex holds lw with rt=8, memRead=1; ID presents add with rs=8 -> hazard_stall=1; next edge ex_valid=0, ex_regWrite=0; following cycle hazard_stall=0 and the add is captured.
- Zero register: ex holds lw with rt=0; ID has rs=0 -> hazard_stall=0, normal capture.
- Flush vs stall: ex_flush=1 and ex_stall=1 on the same edge with a valid sw in ID -> bubble loaded, ex_memWrite=0.
- Stall hold: ex_stall=1 for 3 cycles while id_* changes each cycle -> ex_* unchanged. With PIPE_PERF_CNT_EN, stall_cnt=3; bubble_cnt saturates at FFFF after 65540 forced flushes.
